// File: rtl/slow_clk_monitor.sv
// Samples a slow clock into the clk domain, emits edge pulses, measures half-periods and
// tracks lock/loss. Define SLOW_MON_GLITCH_FILTER_EN to ignore edges shorter than MIN_HALF.
module slow_clk_monitor #(
    parameter int unsigned CNT_W         = 27,
    parameter int unsigned EXPECTED_HALF = 10000000,
    parameter int unsigned TOL           = 1000,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned TIMEOUT       = 20000000,
    parameter int unsigned MIN_HALF      = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0] RANGE_LO =
        (EXPECTED_HALF > TOL) ? (CNT_W+1)'(EXPECTED_HALF - TOL) : '0;
    localparam logic [CNT_W:0] RANGE_HI  = (CNT_W+1)'(EXPECTED_HALF + TOL);
    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(TIMEOUT);
    localparam logic [MW-1:0]  LOCK_V    = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {StIdle, StMeasure, StLost} state_e;

    state_e           state_q, state_d;
    logic             s0_q, s1_q, s2_q;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic             rise_d, fall_d, pv_d, locked_d, lost_d;
    logic [CNT_W-1:0] half_period_d;

    logic             edge_det, accept, in_range, timeout;
    logic [CNT_W:0]   cnt_inc;

    assign edge_det = s1_q ^ s2_q;
    assign cnt_inc  = {1'b0, half_cnt_q} + (CNT_W+1)'(1);
    assign in_range = (cnt_inc >= RANGE_LO) && (cnt_inc <= RANGE_HI);

`ifdef SLOW_MON_GLITCH_FILTER_EN
    localparam logic [CNT_W:0] MIN_V = (CNT_W+1)'(MIN_HALF);
    // Edges arriving too soon after the last accepted one are treated as glitches.
    assign accept = edge_det && !((state_q == StMeasure) && (cnt_inc < MIN_V));
`else
    logic unused_min_half;
    assign unused_min_half = ^MIN_HALF;
    assign accept = edge_det;
`endif

    // A coincident accepted edge always beats the timeout.
    assign timeout = !accept && (cnt_inc == TIMEOUT_V);

    always_comb begin
        state_d       = state_q;
        half_cnt_d    = (half_cnt_q == {CNT_W{1'b1}}) ? half_cnt_q : cnt_inc[CNT_W-1:0];
        match_d       = match_q;
        rise_d        = 1'b0;
        fall_d        = 1'b0;
        pv_d          = 1'b0;
        half_period_d = half_period;
        locked_d      = locked;
        lost_d        = lost;

        if (accept) begin
            half_cnt_d = '0;
            rise_d     = s1_q;
            fall_d     = ~s1_q;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMeasure;
                end else if (timeout) begin
                    state_d  = StLost;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end
            end
            StMeasure: begin
                if (accept) begin
                    half_period_d = cnt_inc[CNT_W] ? half_cnt_q : cnt_inc[CNT_W-1:0];
                    pv_d          = 1'b1;
                    if (in_range) begin
                        if (match_q != LOCK_V) begin
                            match_d = match_q + MW'(1);
                        end
                        locked_d = (match_d == LOCK_V);
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                    end
                end else if (timeout) begin
                    state_d  = StLost;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end
            end
            StLost: begin
                if (accept) begin
                    state_d = StMeasure;
                    lost_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            half_cnt_q   <= '0;
            match_q      <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state_q      <= state_d;
            s0_q         <= slow_clk_in;
            s1_q         <= s0_q;
            s2_q         <= s1_q;
            half_cnt_q   <= half_cnt_d;
            match_q      <= match_d;
            rise_pulse   <= rise_d;
            fall_pulse   <= fall_d;
            half_period  <= half_period_d;
            period_valid <= pv_d;
            locked       <= locked_d;
            lost         <= lost_d;
        end
    end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with small rate parameters; each edge step drives a
// level change and checks pulse timing, half_period, locked and lost against fixed values.
module tb_slow_clk_monitor;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             slow_clk_in;
    logic             rise_pulse, fall_pulse, period_valid, locked, lost;
    logic [CNT_W-1:0] half_period;

    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;
    logic lvl      = 1'b0;

    slow_clk_monitor #(
        .CNT_W         (CNT_W),
        .EXPECTED_HALF (10),
        .TOL           (1),
        .LOCK_COUNT    (4),
        .TIMEOUT       (40),
        .MIN_HALF      (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .slow_clk_in  (slow_clk_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the k-th following rising clk edge.
    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Toggle slow_clk_in, check the pulse three clks later, then hold for n clks in total.
    task automatic edge_step(input int n, input bit exp_pv, input int exp_hp,
                             input bit exp_lock, input bit exp_lost);
        logic nl;
        step++;
        lvl         = !lvl;
        nl          = !lvl;
        slow_clk_in = lvl;
        cyc(2);
        chk("early_pulse", {31'd0, rise_pulse | fall_pulse}, 0);
        cyc(1);
        chk("rise_pulse", {31'd0, rise_pulse}, {31'd0, lvl});
        chk("fall_pulse", {31'd0, fall_pulse}, {31'd0, nl});
        chk("period_valid", {31'd0, period_valid}, {31'd0, exp_pv});
        if (exp_pv) chk("half_period", {24'd0, half_period}, exp_hp);
        chk("locked", {31'd0, locked}, {31'd0, exp_lock});
        chk("lost", {31'd0, lost}, {31'd0, exp_lost});
        cyc(1);
        chk("pulse_width", {31'd0, rise_pulse | fall_pulse}, 0);
        chk("pv_width", {31'd0, period_valid}, 0);
        cyc(n - 4);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {24'd0, half_period}, 0);
        chk(tag, {26'd0, rise_pulse, fall_pulse, period_valid, locked, lost, 1'b0}, 0);
    endtask

    initial begin
        reset       = 1'b1;
        slow_clk_in = 1'b0;
        cyc(2);
        chk_all_zero("reset_values");
        reset = 1'b0;
        cyc(3);
        chk("idle_quiet", {31'd0, rise_pulse | fall_pulse | period_valid}, 0);

        // Lock on the fourth 10-clk measurement, lose it on a 13, relock
        edge_step(10, 0, 0, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(13, 1, 10, 1, 0);
        edge_step(10, 1, 13, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(4, 1, 10, 1, 0);

        // Stop the slow clock: lost exactly 40 clks after the last pulse
        cyc(38);
        chk("lost_early", {31'd0, lost}, 0);
        chk("locked_before_timeout", {31'd0, locked}, 1);
        cyc(1);
        chk("lost_at_timeout", {31'd0, lost}, 1);
        chk("locked_at_timeout", {31'd0, locked}, 0);
        cyc(5);
        chk("lost_sticky", {31'd0, lost}, 1);

        // Resume: first edge clears lost without a measurement, then 9/11 tolerance edges
        edge_step(10, 0, 0, 0, 0);
        edge_step(9, 1, 10, 0, 0);
        edge_step(11, 1, 9, 0, 0);
        edge_step(9, 1, 11, 0, 0);
        edge_step(11, 1, 9, 1, 0);
        edge_step(8, 1, 11, 1, 0);
        edge_step(40, 1, 8, 0, 0);
        // Edge landing on the timeout cycle is a measurement, not a loss
        edge_step(10, 1, 40, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(5, 1, 10, 1, 0);

        // Asynchronous reset while locked
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        lvl         = 1'b0;
        slow_clk_in = 1'b0;
        cyc(2);
        chk_all_zero("reset_held");
        reset = 1'b0;
        cyc(4);
        chk("post_reset_quiet", {31'd0, rise_pulse | fall_pulse | period_valid}, 0);

        edge_step(10, 0, 0, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(10, 1, 10, 0, 0);
        edge_step(5, 1, 10, 1, 0);

`ifndef SLOW_MON_GLITCH_FILTER_EN
        // One-clk glitch 5 clks into a half-period: both edges are accepted
        step++;
        slow_clk_in = !lvl;
        cyc(1);
        slow_clk_in = lvl;
        cyc(1);
        chk("glitch_early", {31'd0, rise_pulse | fall_pulse}, 0);
        cyc(1);
        chk("glitch_first_pulse", {31'd0, lvl ? fall_pulse : rise_pulse}, 1);
        chk("glitch_first_pv", {31'd0, period_valid}, 1);
        chk("glitch_first_hp", {24'd0, half_period}, 5);
        chk("glitch_unlock", {31'd0, locked}, 0);
        cyc(1);
        chk("glitch_second_pulse", {31'd0, lvl ? rise_pulse : fall_pulse}, 1);
        chk("glitch_second_pv", {31'd0, period_valid}, 1);
        chk("glitch_second_hp", {24'd0, half_period}, 1);
        cyc(1);
        chk("glitch_done", {31'd0, rise_pulse | fall_pulse | period_valid}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
